// File: rtl/serial_cpu_core.sv
// Non-pipelined 16-bit CPU: each instruction walks IF, ID, EX, MEM, WB in turn.
// Eight general registers (gr0 hard-wired to zero), external instruction and data memories.
module serial_cpu_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] i_datain,
    input  logic [15:0] d_datain,
    output logic [7:0]  i_addr,
    output logic [7:0]  d_addr,
    output logic        d_we,
    output logic [15:0] d_dataout
);

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_SET   = 5'b10011;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_pc;
    logic [15:0] r_id_ir;
    logic [15:0] r_reg_a;
    logic [15:0] r_reg_b;
    logic [15:0] r_reg_c;
    logic [15:0] r_mem_data;
    logic        r_zf;
    logic        r_nf;
    logic        r_cf;
    logic [15:0] r_gr [8];

    logic [4:0]  w_op;
    logic [2:0]  w_r1;
    logic [2:0]  w_r2;
    logic [2:0]  w_r3;
    logic [7:0]  w_imm8;
    logic [3:0]  w_val4;
    logic [15:0] w_opnd_a;
    logic [15:0] w_opnd_b;
    logic [16:0] w_alu_wide;
    logic [15:0] w_sra;
    logic        w_flag_upd;
    logic        w_taken;
    logic        w_wb_en;
    logic [15:0] w_wb_data;
    logic        w_is_mem_stage;

    // The instruction register stays put for the whole instruction, so every stage decodes from it.
    assign w_op   = r_id_ir[15:11];
    assign w_r1   = r_id_ir[10:8];
    assign w_r2   = r_id_ir[6:4];
    assign w_r3   = r_id_ir[2:0];
    assign w_imm8 = r_id_ir[7:0];
    assign w_val4 = r_id_ir[3:0];

    always_comb begin
        w_state_next = r_state;
        if (enable) begin
            unique case (r_state)
                ST_IDLE: if (start) w_state_next = ST_IF;
                ST_IF:   w_state_next = ST_ID;
                ST_ID:   w_state_next = (w_op == OP_HALT) ? ST_IDLE : ST_EX;
                ST_EX:   w_state_next = ST_MEM;
                ST_MEM:  w_state_next = ST_WB;
                ST_WB:   w_state_next = ST_IF;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Operand selection: everything that is not a plain R-type is folded into an A+B add in EX.
    always_comb begin
        w_opnd_a = r_gr[w_r2];
        w_opnd_b = r_gr[w_r3];
        case (w_op)
            OP_SET, OP_JUMP: begin
                w_opnd_a = 16'h0000;
                w_opnd_b = {8'h00, w_imm8};
            end
            OP_LDIH: begin
                w_opnd_a = r_gr[w_r1];
                w_opnd_b = {w_imm8, 8'h00};
            end
            OP_ADDI, OP_SUBI, OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
                w_opnd_a = r_gr[w_r1];
                w_opnd_b = {8'h00, w_imm8};
            end
            OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_LOAD, OP_STORE: begin
                w_opnd_a = r_gr[w_r2];
                w_opnd_b = {12'h000, w_val4};
            end
            default: ;
        endcase
    end

    assign w_sra = $signed(r_reg_a) >>> r_reg_b[3:0];

    // Bit 16 of the wide result is the carry for adds and the borrow for subtracts; zero otherwise.
    always_comb begin
        w_alu_wide = {1'b0, r_reg_a} + {1'b0, r_reg_b};
        w_flag_upd = 1'b0;
        case (w_op)
            OP_ADD, OP_ADDI:          w_flag_upd = 1'b1;
            OP_ADDC: begin
                w_alu_wide = {1'b0, r_reg_a} + {1'b0, r_reg_b} + {16'h0000, r_cf};
                w_flag_upd = 1'b1;
            end
            OP_SUB, OP_SUBI, OP_CMP: begin
                w_alu_wide = {1'b0, r_reg_a} - {1'b0, r_reg_b};
                w_flag_upd = 1'b1;
            end
            OP_SUBC: begin
                w_alu_wide = {1'b0, r_reg_a} - {1'b0, r_reg_b} - {16'h0000, r_cf};
                w_flag_upd = 1'b1;
            end
            OP_AND: begin w_alu_wide = {1'b0, r_reg_a & r_reg_b}; w_flag_upd = 1'b1; end
            OP_OR:  begin w_alu_wide = {1'b0, r_reg_a | r_reg_b}; w_flag_upd = 1'b1; end
            OP_XOR: begin w_alu_wide = {1'b0, r_reg_a ^ r_reg_b}; w_flag_upd = 1'b1; end
            OP_SLL, OP_SLA: begin
                w_alu_wide = {1'b0, r_reg_a << r_reg_b[3:0]};
                w_flag_upd = 1'b1;
            end
            OP_SRL: begin w_alu_wide = {1'b0, r_reg_a >> r_reg_b[3:0]}; w_flag_upd = 1'b1; end
            OP_SRA: begin w_alu_wide = {1'b0, w_sra}; w_flag_upd = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_JUMP, OP_JMPR: w_taken = 1'b1;
            OP_BZ:            w_taken = r_zf;
            OP_BNZ:           w_taken = ~r_zf;
            OP_BN:            w_taken = r_nf;
            OP_BNN:           w_taken = ~r_nf;
            OP_BC:            w_taken = r_cf;
            OP_BNC:           w_taken = ~r_cf;
            default:          w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_wb_en = 1'b0;
        case (w_op)
            OP_SET, OP_LDIH, OP_ADD, OP_ADDC, OP_ADDI, OP_SUB, OP_SUBC, OP_SUBI,
            OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_LOAD: w_wb_en = 1'b1;
            default: w_wb_en = 1'b0;
        endcase
    end

    assign w_wb_data = (w_op == OP_LOAD) ? r_mem_data : r_reg_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= 8'h00;
            r_id_ir    <= 16'h0000;
            r_reg_a    <= 16'h0000;
            r_reg_b    <= 16'h0000;
            r_reg_c    <= 16'h0000;
            r_mem_data <= 16'h0000;
            r_zf       <= 1'b0;
            r_nf       <= 1'b0;
            r_cf       <= 1'b0;
            for (int i = 0; i < 8; i++) r_gr[i] <= 16'h0000;
        end else if (enable) begin
            r_state <= w_state_next;
            case (r_state)
                ST_IF: begin
                    r_id_ir <= i_datain;
                    r_pc    <= r_pc + 8'd1;
                end
                ST_ID: begin
                    r_reg_a <= w_opnd_a;
                    r_reg_b <= w_opnd_b;
                end
                ST_EX: begin
                    r_reg_c <= w_alu_wide[15:0];
                    if (w_flag_upd) begin
                        r_zf <= (w_alu_wide[15:0] == 16'h0000);
                        r_nf <= w_alu_wide[15];
                        r_cf <= w_alu_wide[16];
                    end
                    if (w_taken) r_pc <= w_alu_wide[7:0];
                end
                ST_MEM: if (w_op == OP_LOAD) r_mem_data <= d_datain;
                ST_WB:  if (w_wb_en && (w_r1 != 3'd0)) r_gr[w_r1] <= w_wb_data;
                default: ;
            endcase
        end
    end

    // Memory outputs are idle-zero outside the MEM stage; d_we is gated so a stall cannot repeat the write.
    assign w_is_mem_stage = (r_state == ST_MEM);
    assign i_addr    = r_pc;
    assign d_addr    = (w_is_mem_stage && (w_op == OP_LOAD || w_op == OP_STORE)) ? r_reg_c[7:0] : 8'h00;
    assign d_we      = enable && w_is_mem_stage && (w_op == OP_STORE);
    assign d_dataout = (w_is_mem_stage && (w_op == OP_STORE)) ? r_gr[w_r1] : 16'h0000;

endmodule

// File: tb/tb_serial_cpu_core.sv
// Bench for serial_cpu_core: instruction-level vector table, hand-written multi-cycle
// scenarios (loop, stall, reset mid-store) and random programs against an ISA model.
module tb_serial_cpu_core;

    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_SET   = 5'b10011;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNC   = 5'b11111;
    localparam logic [15:0] W_HALT  = {OP_HALT, 11'h000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [15:0] i_datain;
    logic [15:0] d_datain;
    logic [7:0]  i_addr;
    logic [7:0]  d_addr;
    logic        d_we;
    logic [15:0] d_dataout;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic [15:0] dmem_init [256];
    logic        dmem_load = 1'b0;
    int          we_cnt = 0;
    logic [7:0]  we_addr = 8'h00;
    logic [15:0] we_data = 16'h0000;

    int n_checks = 0;
    int n_pass = 0;

    int unsigned m_gr [8];
    int unsigned m_mem [256];
    bit          m_z, m_n, m_c;

    typedef struct packed {
        logic [5:0][15:0] prog;
        logic [15:0]      exp_r1;
        logic [2:0]       exp_znc;
    } vec_t;

    serial_cpu_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .start     (start),
        .i_datain  (i_datain),
        .d_datain  (d_datain),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_dataout (d_dataout)
    );

    always #5 clk = ~clk;

    assign i_datain = imem[i_addr];
    assign d_datain = dmem[d_addr];

    always @(posedge clk) begin
        if (dmem_load) begin
            for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
        end else if (d_we) begin
            dmem[d_addr] <= d_dataout;
            we_cnt  <= we_cnt + 1;
            we_addr <= d_addr;
            we_data <= d_dataout;
        end
    end

    function automatic logic [15:0] enc_r(input logic [4:0] op, input int r1, input int r2, input int r3);
        logic [31:0] a, b, c;
        a = r1; b = r2; c = r3;
        return {op, a[2:0], 1'b0, b[2:0], 1'b0, c[2:0]};
    endfunction

    function automatic logic [15:0] enc_i(input logic [4:0] op, input int r1, input int imm);
        logic [31:0] a, b;
        a = r1; b = imm;
        return {op, a[2:0], b[7:0]};
    endfunction

    function automatic logic [15:0] enc_m(input logic [4:0] op, input int r1, input int r2, input int v);
        logic [31:0] a, b, c;
        a = r1; b = r2; c = v;
        return {op, a[2:0], 1'b0, b[2:0], c[3:0]};
    endfunction

    function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                                input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5,
                                input logic [15:0] r1, input logic [2:0] znc);
        vec_t v;
        v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2;
        v.prog[3] = w3; v.prog[4] = w4; v.prog[5] = w5;
        v.exp_r1  = r1;
        v.exp_znc = znc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_prog(input logic [15:0] p[$]);
        for (int i = 0; i < 256; i++) imem[i] = (i < p.size()) ? p[i] : W_HALT;
    endtask

    task automatic load_dmem();
        dmem_load = 1'b1;
        @(negedge clk);
        dmem_load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for the core to fall back to IDLE; cycles counts negedges since the start pulse.
    task automatic wait_idle(input string name, input int budget, inout int cycles);
        while (dut.r_state != 3'd0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (dut.r_state != 3'd0) begin
            n_checks++;
            $display("FAIL %s timeout: state %0d after %0d cycles, required idle", name, dut.r_state, cycles);
        end
    endtask

    // ISA-level reference: one call executes one whole instruction.
    task automatic model_exec(input logic [15:0] w);
        logic [4:0]  op;
        int          r1, r2, r3, imm, v;
        int unsigned res;
        bit          upd, wr, cn;
        op  = w[15:11];
        r1  = int'(w[10:8]);
        r2  = int'(w[6:4]);
        r3  = int'(w[2:0]);
        imm = int'(w[7:0]);
        v   = int'(w[3:0]);
        res = 0; upd = 0; wr = 0; cn = 0;
        case (op)
            OP_SET:  begin res = imm; wr = 1; end
            OP_LDIH: begin res = m_gr[r1] + imm * 256; wr = 1; end
            OP_ADD:  begin res = m_gr[r2] + m_gr[r3]; cn = res > 65535; upd = 1; wr = 1; end
            OP_ADDC: begin res = m_gr[r2] + m_gr[r3] + m_c; cn = res > 65535; upd = 1; wr = 1; end
            OP_ADDI: begin res = m_gr[r1] + imm; cn = res > 65535; upd = 1; wr = 1; end
            OP_SUB:  begin cn = m_gr[r2] < m_gr[r3]; res = m_gr[r2] - m_gr[r3]; upd = 1; wr = 1; end
            OP_SUBC: begin cn = m_gr[r2] < m_gr[r3] + m_c; res = m_gr[r2] - m_gr[r3] - m_c; upd = 1; wr = 1; end
            OP_SUBI: begin cn = m_gr[r1] < imm; res = m_gr[r1] - imm; upd = 1; wr = 1; end
            OP_CMP:  begin cn = m_gr[r2] < m_gr[r3]; res = m_gr[r2] - m_gr[r3]; upd = 1; end
            OP_AND:  begin res = m_gr[r2] & m_gr[r3]; upd = 1; wr = 1; end
            OP_OR:   begin res = m_gr[r2] | m_gr[r3]; upd = 1; wr = 1; end
            OP_XOR:  begin res = m_gr[r2] ^ m_gr[r3]; upd = 1; wr = 1; end
            OP_SLL, OP_SLA: begin res = m_gr[r2] << v; upd = 1; wr = 1; end
            OP_SRL:  begin res = m_gr[r2] >> v; upd = 1; wr = 1; end
            OP_SRA: begin
                res = (m_gr[r2] >> v) | ((m_gr[r2] >= 32768) ? ((32'hFFFF << (16 - v)) & 32'hFFFF) : 0);
                upd = 1; wr = 1;
            end
            OP_LOAD:  begin res = m_mem[(m_gr[r2] + v) % 256]; wr = 1; end
            OP_STORE: m_mem[(m_gr[r2] + v) % 256] = m_gr[r1];
            default: ;
        endcase
        res = res & 32'hFFFF;
        if (upd) begin
            m_z = (res == 0);
            m_n = res[15];
            m_c = cn;
        end
        if (wr && r1 != 0) m_gr[r1] = res;
    endtask

    initial begin : main
        vec_t        vecs [19];
        logic [15:0] prog [$];
        logic [15:0] loop_prog [$];
        logic [4:0]  rops [18];
        logic [4:0]  op;
        int          cycles;
        int          we0;
        int          errs;

        vecs[0]  = mk(enc_i(OP_SET,1,8'hFF), enc_i(OP_LDIH,1,8'hFF), enc_i(OP_ADDI,1,1), W_HALT, W_HALT, W_HALT, 16'h0000, 3'b101);
        vecs[1]  = mk(enc_i(OP_SET,2,5), enc_i(OP_SET,3,7), enc_r(OP_SUB,1,2,3), W_HALT, W_HALT, W_HALT, 16'hFFFE, 3'b011);
        vecs[2]  = mk(enc_i(OP_SET,2,8'hF0), enc_i(OP_SET,3,8'h3C), enc_r(OP_AND,1,2,3), W_HALT, W_HALT, W_HALT, 16'h0030, 3'b000);
        vecs[3]  = mk(enc_i(OP_SET,2,8'hF0), enc_i(OP_SET,3,8'h3C), enc_r(OP_OR,1,2,3), W_HALT, W_HALT, W_HALT, 16'h00FC, 3'b000);
        vecs[4]  = mk(enc_i(OP_SET,2,8'hF0), enc_i(OP_SET,3,8'h3C), enc_r(OP_XOR,1,2,3), W_HALT, W_HALT, W_HALT, 16'h00CC, 3'b000);
        vecs[5]  = mk(enc_i(OP_SET,2,8'h81), enc_m(OP_SLL,1,2,8), W_HALT, W_HALT, W_HALT, W_HALT, 16'h8100, 3'b010);
        vecs[6]  = mk(enc_i(OP_SET,2,8'h80), enc_i(OP_LDIH,2,8'h80), enc_m(OP_SRA,1,2,4), W_HALT, W_HALT, W_HALT, 16'hF808, 3'b010);
        vecs[7]  = mk(enc_i(OP_SET,2,8'h80), enc_i(OP_LDIH,2,8'h80), enc_m(OP_SRL,1,2,4), W_HALT, W_HALT, W_HALT, 16'h0808, 3'b000);
        vecs[8]  = mk(enc_i(OP_SET,1,3), enc_i(OP_SET,2,3), enc_r(OP_CMP,0,1,2), W_HALT, W_HALT, W_HALT, 16'h0003, 3'b100);
        vecs[9]  = mk(enc_i(OP_SET,2,8'hFF), enc_i(OP_LDIH,2,8'hFF), enc_i(OP_SET,3,1), enc_r(OP_ADD,4,2,3), enc_r(OP_ADDC,1,0,0), W_HALT, 16'h0001, 3'b000);
        vecs[10] = mk(enc_i(OP_SET,3,1), enc_r(OP_SUB,4,0,3), enc_r(OP_SUBC,1,0,0), W_HALT, W_HALT, W_HALT, 16'hFFFF, 3'b011);
        vecs[11] = mk(enc_i(OP_SET,0,8'h55), enc_r(OP_ADD,1,0,0), W_HALT, W_HALT, W_HALT, W_HALT, 16'h0000, 3'b100);
        vecs[12] = mk(enc_i(OP_JUMP,0,3), enc_i(OP_SET,1,1), W_HALT, enc_i(OP_SET,1,2), W_HALT, W_HALT, 16'h0002, 3'b000);
        vecs[13] = mk(enc_i(OP_SET,2,8'hF0), enc_i(OP_JMPR,2,8'h14), enc_i(OP_SET,1,1), W_HALT, enc_i(OP_SET,1,9), W_HALT, 16'h0009, 3'b000);
        vecs[14] = mk(enc_i(OP_SET,1,0), enc_i(OP_SUBI,1,1), W_HALT, W_HALT, W_HALT, W_HALT, 16'hFFFF, 3'b011);
        vecs[15] = mk(enc_i(OP_SET,2,3), enc_m(OP_SLA,1,2,15), W_HALT, W_HALT, W_HALT, W_HALT, 16'h8000, 3'b010);
        vecs[16] = mk(enc_i(OP_SET,1,1), enc_r(OP_SUB,2,1,1), enc_i(OP_BZ,0,4), enc_i(OP_SET,1,7), W_HALT, W_HALT, 16'h0001, 3'b100);
        vecs[17] = mk(enc_i(OP_SET,1,1), enc_i(OP_BN,0,4), enc_i(OP_SET,1,7), W_HALT, W_HALT, W_HALT, 16'h0007, 3'b000);
        vecs[18] = mk(enc_i(OP_SET,1,1), enc_i(OP_BNC,0,3), enc_i(OP_SET,1,7), W_HALT, W_HALT, W_HALT, 16'h0001, 3'b000);

        rops = '{OP_ADD, OP_SUB, OP_ADDC, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SUBI,
                 OP_CMP, OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_LOAD, OP_STORE, OP_SET, OP_LDIH};

        for (int i = 0; i < 256; i++) dmem_init[i] = 16'h0000;
        load_prog('{W_HALT});
        do_reset();
        load_dmem();

        chk("reset_pc", 32'(dut.r_pc), 0);
        chk("reset_state", 32'(dut.r_state), 0);
        chk("reset_dwe_daddr_ddata", {d_we, d_addr, d_dataout}, 0);

        // HALT alone: start edge plus IF and ID.
        pulse_start();
        cycles = 1;
        wait_idle("halt_only", 50, cycles);
        chk("halt_latency", cycles, 3);
        chk("halt_pc", 32'(dut.r_pc), 1);

        for (int v = 0; v < 19; v++) begin
            prog = {};
            for (int k = 0; k < 6; k++) prog.push_back(vecs[v].prog[k]);
            load_prog(prog);
            do_reset();
            pulse_start();
            cycles = 1;
            wait_idle($sformatf("vec%0d", v), 200, cycles);
            $display("vector %0d: cycles=%0d gr1=%h", v, cycles, dut.r_gr[1]);
            chk($sformatf("vec%0d_gr1", v), 32'(dut.r_gr[1]), 32'(vecs[v].exp_r1));
            chk($sformatf("vec%0d_flags", v), {dut.r_zf, dut.r_nf, dut.r_cf}, 32'(vecs[v].exp_znc));
        end

        loop_prog = '{enc_i(OP_SET,3,4), enc_i(OP_SET,1,0), enc_r(OP_ADD,1,1,3), enc_i(OP_SUBI,3,1),
                      enc_i(OP_BNZ,0,2), enc_m(OP_STORE,1,0,2), W_HALT};

        // Loop program: 15 five-cycle instructions plus HALT.
        load_prog(loop_prog);
        do_reset();
        load_dmem();
        we0 = we_cnt;
        pulse_start();
        cycles = 1;
        wait_idle("loop", 500, cycles);
        $display("loop program: cycles=%0d", cycles);
        chk("loop_cycles", cycles, 1 + 15 * 5 + 2);
        chk("loop_dram2", 32'(dmem[2]), 32'h000A);
        chk("loop_gr1", 32'(dut.r_gr[1]), 32'h000A);
        chk("loop_gr3", 32'(dut.r_gr[3]), 0);
        chk("loop_zf", 32'(dut.r_zf), 1);
        chk("loop_pc", 32'(dut.r_pc), 7);
        chk("loop_we_count", we_cnt - we0, 1);
        chk("loop_we_addr", 32'(we_addr), 2);
        chk("loop_we_data", 32'(we_data), 32'h000A);

        // LOAD then SUB from zero.
        dmem_init[3] = 16'h3C00;
        load_prog('{enc_i(OP_SET,2,3), enc_m(OP_LOAD,1,2,0), enc_r(OP_SUB,4,0,1), W_HALT});
        do_reset();
        load_dmem();
        pulse_start();
        cycles = 1;
        wait_idle("load_sub", 200, cycles);
        $display("load/sub program: cycles=%0d", cycles);
        chk("load_gr1", 32'(dut.r_gr[1]), 32'h3C00);
        chk("sub_gr4", 32'(dut.r_gr[4]), 32'hC400);
        chk("sub_nf", 32'(dut.r_nf), 1);
        chk("sub_cf", 32'(dut.r_cf), 1);
        dmem_init[3] = 16'h0000;

        // Stall while BNZ of the first iteration sits in EX (cycle 23 after start).
        load_prog(loop_prog);
        do_reset();
        load_dmem();
        we0 = we_cnt;
        pulse_start();
        cycles = 1;
        repeat (22) begin @(negedge clk); cycles++; end
        chk("pre_stall_state", 32'(dut.r_state), 3);
        chk("pre_stall_pc", 32'(dut.r_pc), 5);
        chk("pre_stall_gr1", 32'(dut.r_gr[1]), 4);
        chk("pre_stall_gr3", 32'(dut.r_gr[3]), 3);
        enable = 1'b0;
        start = 1'b1;
        repeat (10) begin @(negedge clk); cycles++; end
        start = 1'b0;
        chk("stall_state", 32'(dut.r_state), 3);
        chk("stall_pc", 32'(dut.r_pc), 5);
        chk("stall_gr1", 32'(dut.r_gr[1]), 4);
        chk("stall_gr3_flags", {dut.r_gr[3], dut.r_zf, dut.r_nf, dut.r_cf}, {16'h0003, 3'b000});
        enable = 1'b1;
        wait_idle("stall_loop", 500, cycles);
        $display("stalled loop program: cycles=%0d", cycles);
        chk("stall_cycles", cycles, 1 + 15 * 5 + 2 + 10);
        chk("stall_dram2", 32'(dmem[2]), 32'h000A);
        chk("stall_gr1_final", 32'(dut.r_gr[1]), 32'h000A);
        chk("stall_pc_final", 32'(dut.r_pc), 7);
        chk("stall_we_count", we_cnt - we0, 1);

        // Reset while STORE is in EX (cycle 8 after start).
        dmem_init[5] = 16'h1234;
        load_prog('{enc_i(OP_SET,1,8'h77), enc_m(OP_STORE,1,0,5), W_HALT});
        do_reset();
        load_dmem();
        we0 = we_cnt;
        pulse_start();
        cycles = 1;
        repeat (7) begin @(negedge clk); cycles++; end
        chk("rst_store_in_ex", 32'(dut.r_state), 3);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        $display("reset during store: released");
        chk("rst_we_count", we_cnt - we0, 0);
        chk("rst_dram5", 32'(dmem[5]), 32'h1234);
        chk("rst_state_idle", 32'(dut.r_state), 0);
        chk("rst_pc", 32'(dut.r_pc), 0);
        chk("rst_ir", 32'(dut.r_id_ir), 0);
        chk("rst_flags", {dut.r_zf, dut.r_nf, dut.r_cf}, 0);
        for (int r = 1; r < 8; r++) chk($sformatf("rst_gr%0d", r), 32'(dut.r_gr[r]), 0);
        dmem_init[5] = 16'h0000;

        // Random straight-line programs against the ISA model.
        for (int t = 0; t < 8; t++) begin
            prog = {};
            for (int r = 1; r < 8; r++) begin
                prog.push_back(enc_i(OP_SET, r, int'($urandom_range(0, 255))));
                prog.push_back(enc_i(OP_LDIH, r, int'($urandom_range(0, 255))));
            end
            for (int k = 0; k < 20; k++) begin
                op = rops[$urandom_range(0, 17)];
                case (op)
                    OP_SET, OP_LDIH, OP_ADDI, OP_SUBI:
                        prog.push_back(enc_i(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 255))));
                    OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_LOAD, OP_STORE:
                        prog.push_back(enc_m(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                             int'($urandom_range(0, 15))));
                    default:
                        prog.push_back(enc_r(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                             int'($urandom_range(0, 7))));
                endcase
            end
            prog.push_back(W_HALT);
            for (int i = 0; i < 256; i++) begin
                dmem_init[i] = 16'($urandom);
                m_mem[i] = 32'(dmem_init[i]);
            end
            for (int r = 0; r < 8; r++) m_gr[r] = 0;
            m_z = 0; m_n = 0; m_c = 0;
            for (int k = 0; k < prog.size() - 1; k++) model_exec(prog[k]);

            load_prog(prog);
            do_reset();
            load_dmem();
            pulse_start();
            cycles = 1;
            wait_idle($sformatf("rand%0d", t), 1000, cycles);
            $display("random program %0d: cycles=%0d", t, cycles);
            for (int r = 1; r < 8; r++)
                chk($sformatf("rand%0d_gr%0d", t, r), 32'(dut.r_gr[r]), m_gr[r]);
            chk($sformatf("rand%0d_flags", t), {dut.r_zf, dut.r_nf, dut.r_cf}, {m_z, m_n, m_c});
            errs = 0;
            for (int i = 0; i < 256; i++) if (32'(dmem[i]) !== m_mem[i]) errs++;
            chk($sformatf("rand%0d_dmem_mismatches", t), errs, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
